// File: rtl/bmp180_pkg.sv
// Shared constants for the BMP180 I2C target: register map, commands,
// conversion times and the bus state encoding.
package bmp180_pkg;

    localparam logic [7:0] REG_CAL_FIRST = 8'hAA;
    localparam logic [7:0] REG_CAL_LAST  = 8'hBF;
    localparam logic [7:0] REG_CHIP_ID   = 8'hD0;
    localparam logic [7:0] REG_SOFT_RST  = 8'hE0;
    localparam logic [7:0] REG_CTRL      = 8'hF4;
    localparam logic [7:0] REG_OUT_MSB   = 8'hF6;
    localparam logic [7:0] REG_OUT_LSB   = 8'hF7;
    localparam logic [7:0] REG_OUT_XLSB  = 8'hF8;

    localparam logic [7:0] CMD_T    = 8'h2E;
    localparam logic [7:0] CMD_P    = 8'h34;
    localparam logic [7:0] SOFT_RST = 8'hB6;

    localparam real T_CONV_TEMP = 4.5e-3;
    localparam real T_CONV_P0   = 4.5e-3;
    localparam real T_CONV_P1   = 7.5e-3;
    localparam real T_CONV_P2   = 13.5e-3;
    localparam real T_CONV_P3   = 25.5e-3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_A_ACK,
        ST_REG,
        ST_R_ACK,
        ST_WDATA,
        ST_W_ACK,
        ST_RDATA,
        ST_M_ACK
    } bus_state_t;

endpackage

// File: rtl/i2c_slv_line_sync.sv
// SCL/SDA two-flop synchronisers with a history flop; produces SCL edge
// strobes and START/STOP detection from the synchronised levels.
module i2c_slv_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    always_comb begin
        scl_rise  = scl_q[1] & ~scl_q[2];
        scl_fall  = ~scl_q[1] & scl_q[2];
        start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
        stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
        sda_level = sda_q[1];
    end

endmodule

// File: rtl/bmp180_i2c_slave.sv
// I2C target emulating the BMP180: address decode, register map and conversion timer.
// Defining BMP180_SLV_NACK_INJ_EN adds I_NACK_INJ to withhold the address ACK.
module bmp180_i2c_slave
    import bmp180_pkg::*;
#(
    parameter int unsigned  FPGA_CLK = 50_000_000,
    parameter logic [6:0]   I2C_ADDR = 7'h77,
    parameter logic [7:0]   CHIP_ID  = 8'h55,
    parameter logic [175:0] CAL_INIT = 176'h0198_FFB8_C7D1_7FE5_7FF5_5A71_182E_0004_8000_DDF9_0B34
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        IO_SCL,
    inout  wire         IO_SDA,
`ifdef BMP180_SLV_NACK_INJ_EN
    input  logic        I_NACK_INJ,
`endif
    input  logic [15:0] I_UT,
    input  logic [18:0] I_UP,
    output logic [7:0]  O_CTRL,
    output logic        O_BUSY,
    output logic        O_ACT
);

    localparam int unsigned N_TEMP = int'(real'(FPGA_CLK) * T_CONV_TEMP);
    localparam int unsigned N_P0   = int'(real'(FPGA_CLK) * T_CONV_P0);
    localparam int unsigned N_P1   = int'(real'(FPGA_CLK) * T_CONV_P1);
    localparam int unsigned N_P2   = int'(real'(FPGA_CLK) * T_CONV_P2);
    localparam int unsigned N_P3   = int'(real'(FPGA_CLK) * T_CONV_P3);
    localparam int unsigned TW     = $clog2(N_P3 + 1);

    logic scl_rise, scl_fall, start_det, stop_det, sda_in, nack_inj;

    bus_state_t state, state_next;
    logic [3:0]  cnt;
    logic [7:0]  sr;
    logic [6:0]  tx;
    logic [7:0]  ptr;
    logic        sda_oe, oe_next;
    logic        act, act_next;
    logic        shift_in, cnt_clr, load_ptr, wr_en, load_tx, shift_tx;
    logic [7:0]  rd_byte;
    logic [7:0]  cal_sel;
    logic [7:0]  ctrl;
    logic [23:0] out_data;
    logic [TW-1:0] timer, timer_load;
    logic [3:0]  p_shamt;
    logic [23:0] p_out;
    logic        wr_ctrl, wr_srst;

`ifdef BMP180_SLV_NACK_INJ_EN
    assign nack_inj = I_NACK_INJ;
`else
    assign nack_inj = 1'b0;
`endif

    i2c_slv_line_sync u_sync (
        .clk       (CLK),
        .rst_n     (RST_n),
        .scl       (IO_SCL),
        .sda       (IO_SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_in)
    );

    assign IO_SDA = sda_oe ? 1'b0 : 1'bz;
    assign O_CTRL = ctrl;
    assign O_BUSY = ctrl[5];
    assign O_ACT  = act;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Every state change lands on a synchronised SCL fall, so SDA only moves while SCL is low.
    always_comb begin
        state_next = state;
        oe_next    = sda_oe;
        act_next   = act;
        shift_in   = 1'b0;
        cnt_clr    = 1'b0;
        load_ptr   = 1'b0;
        wr_en      = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        if (stop_det) begin
            state_next = ST_IDLE;
            oe_next    = 1'b0;
            act_next   = 1'b0;
            cnt_clr    = 1'b1;
        end else if (start_det) begin
            state_next = ST_ADDR;
            oe_next    = 1'b0;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    shift_in = scl_rise;
                    if (scl_fall && cnt == 4'd8) begin
                        cnt_clr = 1'b1;
                        if (state == ST_ADDR) begin
                            if (sr[7:1] == I2C_ADDR && !nack_inj) begin
                                state_next = ST_A_ACK;
                                oe_next    = 1'b1;
                                act_next   = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                                act_next   = 1'b0;
                            end
                        end else if (state == ST_REG) begin
                            load_ptr   = 1'b1;
                            state_next = ST_R_ACK;
                            oe_next    = 1'b1;
                        end else begin
                            wr_en      = 1'b1;
                            state_next = ST_W_ACK;
                            oe_next    = 1'b1;
                        end
                    end
                end
                ST_A_ACK: begin
                    if (scl_fall) begin
                        if (sr[0]) begin
                            state_next = ST_RDATA;
                            load_tx    = 1'b1;
                            cnt_clr    = 1'b1;
                            oe_next    = ~rd_byte[7];
                        end else begin
                            state_next = ST_REG;
                            oe_next    = 1'b0;
                        end
                    end
                end
                ST_R_ACK, ST_W_ACK: begin
                    if (scl_fall) begin
                        state_next = ST_WDATA;
                        oe_next    = 1'b0;
                    end
                end
                ST_RDATA: begin
                    shift_in = scl_rise;
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_next = ST_M_ACK;
                            oe_next    = 1'b0;
                        end else begin
                            shift_tx = 1'b1;
                            oe_next  = ~tx[6];
                        end
                    end
                end
                ST_M_ACK: begin
                    shift_in = scl_rise;
                    if (scl_fall) begin
                        if (!sr[0]) begin
                            state_next = ST_RDATA;
                            load_tx    = 1'b1;
                            cnt_clr    = 1'b1;
                            oe_next    = ~rd_byte[7];
                        end else begin
                            state_next = ST_IDLE;
                            act_next   = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt    <= '0;
            sr     <= '0;
            tx     <= '0;
            ptr    <= '0;
            sda_oe <= 1'b0;
            act    <= 1'b0;
        end else begin
            sda_oe <= oe_next;
            act    <= act_next;
            if (cnt_clr)       cnt <= '0;
            else if (shift_in) cnt <= cnt + 4'd1;
            if (shift_in) sr <= {sr[6:0], sda_in};
            if (load_ptr)              ptr <= sr;
            else if (wr_en || load_tx) ptr <= ptr + 8'd1;
            if (load_tx)       tx <= rd_byte[6:0];
            else if (shift_tx) tx <= {tx[5:0], 1'b0};
        end
    end

    always_comb begin
        rd_byte = '0;
        cal_sel = 8'd21 - (ptr - REG_CAL_FIRST);
        if (ptr >= REG_CAL_FIRST && ptr <= REG_CAL_LAST) begin
            rd_byte = CAL_INIT[{cal_sel, 3'b000} +: 8];
        end else begin
            case (ptr)
                REG_CHIP_ID:  rd_byte = CHIP_ID;
                REG_CTRL:     rd_byte = ctrl;
                REG_OUT_MSB:  rd_byte = out_data[23:16];
                REG_OUT_LSB:  rd_byte = out_data[15:8];
                REG_OUT_XLSB: rd_byte = out_data[7:0];
                default:      rd_byte = '0;
            endcase
        end
    end

    always_comb begin
        timer_load = TW'(N_TEMP - 1);
        if (sr[4:0] == CMD_P[4:0]) begin
            case (sr[7:6])
                2'd0:    timer_load = TW'(N_P0 - 1);
                2'd1:    timer_load = TW'(N_P1 - 1);
                2'd2:    timer_load = TW'(N_P2 - 1);
                default: timer_load = TW'(N_P3 - 1);
            endcase
        end
        p_shamt = 4'd8 - {2'b00, ctrl[7:6]};
        p_out   = {5'b0, I_UP} << p_shamt;
        wr_ctrl = wr_en && ptr == REG_CTRL && !ctrl[5];
        wr_srst = wr_en && ptr == REG_SOFT_RST && sr == SOFT_RST;
    end

    // Timer is loaded with N-1 so sco stays high for exactly N clocks.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ctrl     <= '0;
            out_data <= '0;
            timer    <= '0;
        end else if (wr_srst) begin
            ctrl     <= '0;
            out_data <= '0;
            timer    <= '0;
        end else if (wr_ctrl) begin
            ctrl  <= sr;
            timer <= timer_load;
        end else if (ctrl[5]) begin
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                ctrl[5] <= 1'b0;
                if (ctrl[4:0] == CMD_T[4:0])      out_data <= {I_UT, 8'h00};
                else if (ctrl[4:0] == CMD_P[4:0]) out_data <= p_out;
            end
        end
    end

endmodule

// File: tb/tb_bmp180_i2c_slave.sv
// Directed bench for bmp180_i2c_slave: bit-banged I2C master with immediate-assertion checks.
module tb_bmp180_i2c_slave;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned Q      = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda_bus;
    logic [15:0] ut = '0;
    logic [18:0] up = '0;
    logic [7:0]  ctrl;
    logic        busy;
    logic        act;
`ifdef BMP180_SLV_NACK_INJ_EN
    logic        nack_inj = 1'b0;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    time         t_rise = 0;
    time         t_fall = 0;
    logic        ack;
    logic [7:0]  b;
    logic [7:0]  rd [32];
    logic [7:0]  cal_exp [22] = '{8'h01, 8'h98, 8'hFF, 8'hB8, 8'hC7, 8'hD1, 8'h7F, 8'hE5,
                                  8'h7F, 8'hF5, 8'h5A, 8'h71, 8'h18, 8'h2E, 8'h00, 8'h04,
                                  8'h80, 8'h00, 8'hDD, 8'hF9, 8'h0B, 8'h34};

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;
    always @(posedge busy) t_rise = $time;
    always @(negedge busy) t_fall = $time;

    bmp180_i2c_slave #(.FPGA_CLK(CLK_HZ)) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .IO_SCL     (scl),
        .IO_SDA     (sda_bus),
`ifdef BMP180_SLV_NACK_INJ_EN
        .I_NACK_INJ (nack_inj),
`endif
        .I_UT       (ut),
        .I_UP       (up),
        .O_CTRL     (ctrl),
        .O_BUSY     (busy),
        .O_ACT      (act)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b1; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~d[i]; #(Q);
            scl = 1'b1;    #(2*Q);
            scl = 1'b0;    #(Q);
        end
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        a = sda_bus;  #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_low = 1'b0;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            #(Q); scl = 1'b1;
            #(Q); d = {d[6:0], sda_bus};
            #(Q); scl = 1'b0;
        end
        #(Q); m_low = ~nack;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #(Q); m_low = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        logic a;
        i2c_start();
        write_byte(8'hEE, a); check("wr_ack_dev", a, 0);
        write_byte(addr, a);  check("wr_ack_ptr", a, 0);
        write_byte(data, a);  check("wr_ack_data", a, 0);
        i2c_stop();
    endtask

    task automatic reg_read(input logic [7:0] addr, input int n);
        logic a;
        i2c_start();
        write_byte(8'hEE, a); check("rd_ack_dev_w", a, 0);
        write_byte(addr, a);  check("rd_ack_ptr", a, 0);
        i2c_start();
        write_byte(8'hEF, a); check("rd_ack_dev_r", a, 0);
        for (int i = 0; i < n; i++) read_byte(i == n - 1, rd[i]);
        i2c_stop();
    endtask

    task automatic wait_conv_done(input string tag);
        int unsigned k = 0;
        while (busy && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctrl", ctrl, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_act", act, 0);
        check("rst_sda", sda_bus, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // chip id via register-read sequence with repeated START
        i2c_start();
        write_byte(8'hEE, ack); check("t1_ack_w", ack, 0);
        check("t1_act", act, 1);
        write_byte(8'hD0, ack); check("t1_ack_ptr", ack, 0);
        i2c_start();
        write_byte(8'hEF, ack); check("t1_ack_r", ack, 0);
        read_byte(1'b1, b);
        check("t1_chip_id", b, 8'h55);
        check("t1_sda_rel", sda_bus, 1);
        check("t1_act_nack", act, 0);
        i2c_stop();

        // calibration burst plus one byte past the table
        reg_read(8'hAA, 23);
        for (int i = 0; i < 22; i++) check($sformatf("t2_cal%0d", i), rd[i], cal_exp[i]);
        check("t2_c0", rd[22], 8'h00);

        // temperature conversion
        ut = 16'h6CFA;
        reg_write(8'hF4, 8'h2E);
        check("t3_busy", busy, 1);
        check("t3_ctrl", ctrl, 8'h2E);
        reg_read(8'hF4, 1);
        check("t3_rd_ctrl_busy", rd[0], 8'h2E);
        wait_conv_done("t3_done");
        check("t3_busy_len", 32'((t_fall - t_rise) / 10), 4500);
        check("t3_ctrl_done", ctrl, 8'h0E);
        reg_read(8'hF4, 1);
        check("t3_rd_ctrl_done", rd[0], 8'h0E);
        reg_read(8'hF6, 3);
        check("t3_f6", rd[0], 8'h6C);
        check("t3_f7", rd[1], 8'hFA);
        check("t3_f8", rd[2], 8'h00);

        // pressure conversion oss=3, second write while busy dropped
        up = 19'h5A5A5;
        reg_write(8'hF4, 8'hF4);
        check("t4_ctrl", ctrl, 8'hF4);
        reg_write(8'hF4, 8'h2E);
        check("t4_ctrl_ignored", ctrl, 8'hF4);
        wait_conv_done("t4_done");
        check("t4_busy_len", 32'((t_fall - t_rise) / 10), 25500);
        check("t4_ctrl_done", ctrl, 8'hD4);
        reg_read(8'hF6, 3);
        check("t4_f6", rd[0], 8'hB4);
        check("t4_f7", rd[1], 8'hB4);
        check("t4_f8", rd[2], 8'hA0);

        // foreign address
        i2c_start();
        write_byte(8'hEA, ack); check("t5_no_ack", ack, 1);
        check("t5_act", act, 0);
        i2c_stop();
`ifdef BMP180_SLV_NACK_INJ_EN
        nack_inj = 1'b1;
        i2c_start();
        write_byte(8'hEE, ack); check("t5_inj_nack", ack, 1);
        check("t5_inj_act", act, 0);
        i2c_stop();
        nack_inj = 1'b0;
`endif

        // soft reset during conversion
        reg_write(8'hF4, 8'h2E);
        check("t6_busy", busy, 1);
        reg_write(8'hE0, 8'hB6);
        check("t6_srst_busy", busy, 0);
        check("t6_srst_ctrl", ctrl, 8'h00);
        reg_read(8'hF6, 1);
        check("t6_out_clr", rd[0], 8'h00);

        // hard reset while the target drives a 0 data bit
        i2c_start();
        write_byte(8'hEE, ack); check("t6_ack_w", ack, 0);
        write_byte(8'hAA, ack); check("t6_ack_ptr", ack, 0);
        i2c_start();
        write_byte(8'hEF, ack); check("t6_ack_r", ack, 0);
        m_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q);
        check("t6_drive0", sda_bus, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda", sda_bus, 1);
        check("t6_rst_act", act, 0);
        #(Q - 1); scl = 1'b0;
        #(Q); rst_n = 1'b1;
        #(Q);
        i2c_stop();
        check("t6_rst_ctrl", ctrl, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
